// File: rtl/fir_17_tap.sv
// 17-tap symmetric low-pass FIR, one signed sample per valid clock, full-precision registered output.
// Latency: one edge from accepting a sample to data_o; valid_i=0 freezes delay line and output (no backpressure).
module fir_17_tap #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 10,
  parameter int OUT_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  data_i,
  input  logic                    valid_i,
  output logic signed [OUT_W-1:0] data_o
);

  localparam int NTAP = 17;
  localparam int HALF = 8;

  function automatic logic signed [COEF_W-1:0] coef(input int k);
    case (k)
      0:       coef = COEF_W'(-2);
      1:       coef = COEF_W'(-4);
      2:       coef = COEF_W'(-3);
      3:       coef = COEF_W'(6);
      4:       coef = COEF_W'(22);
      5:       coef = COEF_W'(44);
      6:       coef = COEF_W'(68);
      7:       coef = COEF_W'(87);
      default: coef = COEF_W'(94);
    endcase
  endfunction

  logic signed [IN_W-1:0]  x_q [1:NTAP-1];
  logic signed [IN_W-1:0]  tap [0:NTAP-1];
  logic signed [OUT_W-1:0] pre;
  logic signed [OUT_W-1:0] acc_d;
  logic signed [OUT_W-1:0] data_q;

  // Symmetric pairs share one coefficient: pre-add the mirrored taps, then multiply once.
  always_comb begin
    tap[0] = data_i;
    for (int k = 1; k < NTAP; k++) begin
      tap[k] = x_q[k];
    end
    acc_d = '0;
    pre   = '0;
    for (int k = 0; k < HALF; k++) begin
      pre   = OUT_W'(tap[k]) + OUT_W'(tap[NTAP-1-k]);
      acc_d = acc_d + pre * OUT_W'(coef(k));
    end
    acc_d = acc_d + OUT_W'(tap[HALF]) * OUT_W'(coef(HALF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < NTAP; k++) begin
        x_q[k] <= '0;
      end
      data_q <= '0;
    end else if (valid_i) begin
      x_q[1] <= data_i;
      for (int k = 2; k < NTAP; k++) begin
        x_q[k] <= x_q[k-1];
      end
      data_q <= acc_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_fir_17_tap.sv
// Bench for fir_17_tap: directed impulse/step/gap/reset cases plus a long random stream against a convolution model.
module tb_fir_17_tap;

  logic               clk;
  logic               rst;
  logic signed [7:0]  data_i;
  logic               valid_i;
  logic signed [23:0] data_o;

  int total_cnt;
  int bad_cnt;
  int hist [16];
  int hc [17] = '{-2, -4, -3, 6, 22, 44, 68, 87, 94, 87, 68, 44, 22, 6, -3, -4, -2};
  int sbq [$];
  int last_exp;

  fir_17_tap dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .valid_i(valid_i),
    .data_o (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [23:0] got, input int exp);
    logic signed [31:0] g;
    g = got;
    total_cnt++;
    if (g !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, g, exp);
    end
  endtask

  function automatic int model_push(input int s);
    int acc;
    acc = hc[0] * s;
    for (int k = 1; k < 17; k++) acc += hc[k] * hist[k-1];
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    return acc;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) hist[k] = 0;
    sbq.delete();
    last_exp = 0;
  endtask

  // One clock: drive at negedge, check just after the following rising edge.
  task automatic drive(input logic v, input int d);
    int exp;
    @(negedge clk);
    valid_i = v;
    data_i  = 8'(d);
    if (v) sbq.push_back(model_push(d));
    @(posedge clk);
    #1;
    if (v) begin
      if (sbq.size() == 0) begin
        check_eq("sb_empty", data_o, 0);
      end else begin
        exp = sbq.pop_front();
        last_exp = exp;
        check_eq("sb", data_o, exp);
      end
    end else begin
      check_eq("hold", data_o, last_exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_async", data_o, 0);
    model_clear();
    valid_i = 1'b1;
    data_i  = 8'sd55;
    @(posedge clk);
    #1;
    check_eq("rst_ignores_valid", data_o, 0);
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  int imp [17] = '{-2, -4, -3, 6, 22, 44, 68, 87, 94, 87, 68, 44, 22, 6, -3, -4, -2};

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    model_clear();
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    #1;
    check_eq("reset_state", data_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Unit impulse
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i == 0) ? 1 : 0);
      check_eq("impulse", data_o, (i < 17) ? imp[i] : 0);
    end

    // Impulse with a 3-cycle valid gap after the 5th sample
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, (i == 0) ? 1 : 0);
    check_eq("gap_pre", data_o, 22);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom_range(1, 127));
      check_eq("gap_hold", data_o, 22);
    end
    for (int i = 5; i < 17; i++) begin
      drive(1'b1, 0);
      check_eq("gap_resume", data_o, imp[i]);
    end

    // Negative full-scale impulse
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, (i == 0) ? -128 : 0);
      check_eq("neg_impulse", data_o, -128 * imp[i]);
    end

    // Positive then negative full-scale steps
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 127);
      if (i == 0) check_eq("step_p0", data_o, -254);
      if (i == 1) check_eq("step_p1", data_o, -762);
      if (i == 2) check_eq("step_p2", data_o, -1143);
      if (i >= 16) check_eq("step_p_settle", data_o, 67310);
    end
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, -128);
      if (i >= 16) check_eq("step_n_settle", data_o, -67840);
    end

    // Reset with a non-zero delay line, then zeros must stay zero
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 0);
      check_eq("post_rst_zero", data_o, 0);
    end

    // Random stream with a mid-stream reset
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) do_reset();
      drive(1'b1, int'($urandom_range(0, 255)) - 128);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/fir_17_tap.md
Name: fir_17_tap

Overview:
- 17-tap direct-form FIR low-pass filter with fixed, symmetric integer coefficients.
- Accepts one signed 8-bit sample per clock when valid_i is high.
- Produces a registered, full-precision signed 24-bit result.
- Sits in the sample datapath between a noise/ADC sample source and downstream logging or processing.

Parameters:
- IN_W, 8, input sample width (signed two's complement).
- COEF_W, 10, coefficient width (signed two's complement).
- OUT_W, 24, output width. Must be ≥ IN_W+COEF_W+5; only the defaults are required to be supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- data_i  input  8  signed input sample.
- valid_i  input  1  sample-valid qualifier; data_i is accepted on a rising edge while high.
- data_o  output  24  signed filter output, registered.

Behaviour:
- Coefficients are fixed (localparams), symmetric, h[k] = h[16-k]:
  - h0..h8 = -2, -4, -3, 6, 22, 44, 68, 87, 94.
  - h9..h16 mirror h7..h0.
  - Sum = 530; sum of |h| = 566.
- Delay line: 16 registers x1..x16, each IN_W signed, holding previous accepted samples (x1 = most recent).
- On a rising edge with valid_i=1:
  - data_o <= h0*data_i + sum over k=1..16 of h[k]*x[k].
  - x1 <= data_i; x[k] <= x[k-1] for k=2..16.
- Latency: the output reflecting sample n appears on data_o immediately after the edge that accepts sample n (one register stage).
- On a rising edge with valid_i=0: delay line and data_o hold their values. No shift, no update.
- Arithmetic:
  - All products and sums are signed, sign-extended to OUT_W before accumulation.
  - No rounding, truncation or saturation.
  - Worst-case magnitude is 128*566 = 72448, below 2^23, so overflow cannot occur.
- Output changes only on a valid edge; the output is never combinational from data_i.
- Reset (asynchronous, any time, including mid-stream):
  - All delay registers and data_o go to 0 immediately.
  - While rst=1, valid_i is ignored.
  - After release, the filter behaves as if all prior samples were zero.
- Summation structure (adder tree, pre-adder exploiting symmetry, etc.) is free, provided the result is bit-exact and the latency is exactly as above with no extra pipeline stages.

Test Plan:
- Reset: assert rst with a nonzero delay line -> data_o = 0 immediately, without waiting for a clock edge; after release with data_i=0, valid_i=1, data_o stays 0.
- Impulse: data_i = 1 for one valid cycle, then 0 -> data_o sequence after successive edges is -2, -4, -3, 6, 22, 44, 68, 87, 94, 87, 68, 44, 22, 6, -3, -4, -2, then 0 thereafter.
- Negative full-scale impulse: data_i = -128 once, then 0 -> peak data_o = -12032 on the 9th edge; first output = 256; outputs are sign-correct throughout.
- Step: data_i = 127 held with valid_i=1 -> data_o ramps (-254, -762, -1143, ...) and settles at 67310 from the 17th edge onward; with data_i = -128 held, it settles at -67840.
- Valid gaps: during the impulse test, drop valid_i for 3 cycles after the 5th sample -> data_o holds 22 during the gap and then resumes with 44, 68, ... (no samples lost or duplicated).
- Random stream: 10000 random signed 8-bit samples, valid_i=1 continuously -> data_o matches a bit-exact reference convolution every cycle; includes a mid-stream reset that clears history.
